// File: rtl/id_issue_ctrl.sv
// ============================================================================
// Module   : id_issue_ctrl
// Brief    : ID-stage issue control. Inserts load-use bubbles and sequences
//            terminate -> drain -> halt. The optional load-use stall counter
//            is enabled by defining ISSUE_STALL_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_issue_ctrl #(
  parameter int DRAIN_CYCLES = 4,
  parameter int WORD         = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_dec_valid,
  input  logic            i_dec_mem_w,
  input  logic            i_dec_mem_r,
  input  logic            i_dec_wb_en,
  input  logic            i_dec_terminate,
  input  logic [3:0]      i_dec_alu_op,
  input  logic [4:0]      i_dec_rs,
  input  logic [4:0]      i_dec_rt,
  input  logic [4:0]      i_dec_dest,
  input  logic            i_dec_uses_rs,
  input  logic            i_dec_uses_rt,
  input  logic            i_ex_mem_r,
  input  logic [4:0]      i_ex_reg_dest,
  output logic            o_iss_mem_w,
  output logic            o_iss_mem_r,
  output logic            o_iss_wb_en,
  output logic            o_iss_terminate,
  output logic [3:0]      o_iss_alu_op,
  output logic [4:0]      o_iss_rs,
  output logic [4:0]      o_iss_rt,
  output logic [4:0]      o_iss_dest,
  output logic            o_stall,
  output logic            o_halted,
  output logic [WORD-1:0] o_stall_count
);

  localparam logic [3:0] c_CNT_INIT = 4'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_DRAIN = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  state_t     r_state;
  logic [3:0] r_cnt;
  logic       r_halted;
  logic       w_haz;
  logic       w_issue;

  // EX holds a load whose destination this instruction still needs to read.
  assign w_haz = i_dec_valid & i_ex_mem_r & (i_ex_reg_dest != 5'd0) &
                 ((i_dec_uses_rs & (i_dec_rs == i_ex_reg_dest)) |
                  (i_dec_uses_rt & (i_dec_rt == i_ex_reg_dest)));

  assign w_issue = rst & (r_state == S_RUN) & i_dec_valid & ~w_haz;

  always_comb begin
    o_iss_mem_w     = 1'b0;
    o_iss_mem_r     = 1'b0;
    o_iss_wb_en     = 1'b0;
    o_iss_terminate = 1'b0;
    o_iss_alu_op    = 4'd0;
    o_iss_rs        = 5'd0;
    o_iss_rt        = 5'd0;
    o_iss_dest      = 5'd0;
    o_stall         = 1'b0;
    if (rst) begin
      o_stall = (r_state != S_RUN) | w_haz;
      if (w_issue) begin
        o_iss_mem_w     = i_dec_mem_w;
        o_iss_mem_r     = i_dec_mem_r;
        o_iss_wb_en     = i_dec_wb_en;
        o_iss_terminate = i_dec_terminate;
        o_iss_alu_op    = i_dec_alu_op;
        o_iss_rs        = i_dec_rs;
        o_iss_rt        = i_dec_rt;
        o_iss_dest      = i_dec_dest;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= S_RUN;
      r_cnt    <= 4'd0;
      r_halted <= 1'b0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (w_issue && i_dec_terminate) begin
            r_state <= S_DRAIN;
            r_cnt   <= c_CNT_INIT;
          end
        end
        S_DRAIN: begin
          if (r_cnt == 4'd0) begin
            r_state  <= S_HALT;
            r_halted <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_HALT:  r_halted <= 1'b1;
        default: r_state  <= S_RUN;
      endcase
    end
  end

  assign o_halted = r_halted;

`ifdef ISSUE_STALL_CNT_EN
  logic [WORD-1:0] r_stall_count;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_stall_count <= '0;
    end else if ((r_state == S_RUN) && w_haz && (r_stall_count != '1)) begin
      r_stall_count <= r_stall_count + 1'b1;
    end
  end

  assign o_stall_count = r_stall_count;
`else
  assign o_stall_count = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_id_issue_ctrl.sv
// ============================================================================
// Module   : tb_id_issue_ctrl
// Brief    : Directed self-checking bench for id_issue_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_id_issue_ctrl;

  localparam int WORD = 16;
`ifdef ISSUE_STALL_CNT_EN
  localparam bit c_CNT_EN = 1'b1;
`else
  localparam bit c_CNT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic dec_valid, dec_mem_w, dec_mem_r, dec_wb_en, dec_terminate;
  logic [3:0] dec_alu_op;
  logic [4:0] dec_rs, dec_rt, dec_dest;
  logic dec_uses_rs, dec_uses_rt, ex_mem_r;
  logic [4:0] ex_reg_dest;
  logic iss_mem_w, iss_mem_r, iss_wb_en, iss_terminate;
  logic [3:0] iss_alu_op;
  logic [4:0] iss_rs, iss_rt, iss_dest;
  logic stall, halted;
  logic [WORD-1:0] stall_count;

  int n_tests = 0;
  int n_fail  = 0;
  int sc_exp  = 0;

  always #5 clk = ~clk;

  id_issue_ctrl #(.DRAIN_CYCLES(4), .WORD(WORD)) u_dut (
    .clk(clk), .rst(rst),
    .i_dec_valid(dec_valid), .i_dec_mem_w(dec_mem_w), .i_dec_mem_r(dec_mem_r),
    .i_dec_wb_en(dec_wb_en), .i_dec_terminate(dec_terminate),
    .i_dec_alu_op(dec_alu_op), .i_dec_rs(dec_rs), .i_dec_rt(dec_rt),
    .i_dec_dest(dec_dest), .i_dec_uses_rs(dec_uses_rs), .i_dec_uses_rt(dec_uses_rt),
    .i_ex_mem_r(ex_mem_r), .i_ex_reg_dest(ex_reg_dest),
    .o_iss_mem_w(iss_mem_w), .o_iss_mem_r(iss_mem_r), .o_iss_wb_en(iss_wb_en),
    .o_iss_terminate(iss_terminate), .o_iss_alu_op(iss_alu_op),
    .o_iss_rs(iss_rs), .o_iss_rt(iss_rt), .o_iss_dest(iss_dest),
    .o_stall(stall), .o_halted(halted), .o_stall_count(stall_count)
  );

  wire [22:0] w_iss = {iss_mem_w, iss_mem_r, iss_wb_en, iss_terminate,
                       iss_alu_op, iss_rs, iss_rt, iss_dest};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected issue vector is the decoded instruction as currently driven.
  function automatic logic [22:0] pass_vec();
    return {dec_mem_w, dec_mem_r, dec_wb_en, dec_terminate,
            dec_alu_op, dec_rs, dec_rt, dec_dest};
  endfunction

  task automatic set_dec(input logic v, input logic mw, input logic mr, input logic wb,
                         input logic term, input logic [3:0] op, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [4:0] dst,
                         input logic urs, input logic urt);
    dec_valid = v; dec_mem_w = mw; dec_mem_r = mr; dec_wb_en = wb;
    dec_terminate = term; dec_alu_op = op; dec_rs = rs; dec_rt = rt;
    dec_dest = dst; dec_uses_rs = urs; dec_uses_rt = urt;
  endtask

  task automatic set_ex(input logic mr, input logic [4:0] dst);
    ex_mem_r = mr; ex_reg_dest = dst;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cycle(input string tag, input logic [22:0] iss_e,
                           input logic stall_e, input logic halted_e);
    chk({tag, ".iss"},    32'(w_iss),       32'(iss_e));
    chk({tag, ".stall"},  32'(stall),       32'(stall_e));
    chk({tag, ".halted"}, 32'(halted),      32'(halted_e));
    chk({tag, ".scnt"},   32'(stall_count), c_CNT_EN ? 32'(sc_exp) : 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    set_ex(1'b0, 5'd0);
    set_dec(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'h5, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1);
    tick();

    // Reset held two cycles with a valid terminate presented.
    settle(); chk_cycle("rst0", 23'd0, 1'b0, 1'b0);
    tick();
    settle(); chk_cycle("rst1", 23'd0, 1'b0, 1'b0);
    tick();
    rst = 1'b1;
    set_dec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    settle(); chk_cycle("idle", 23'd0, 1'b0, 1'b0);
    tick();

    // Plain issue.
    set_dec(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'hA, 5'd3, 5'd4, 5'd9, 1'b1, 1'b1);
    settle(); chk_cycle("issue", 23'b1_0_0_0_1010_00011_00100_01001, 1'b0, 1'b0);
    tick();

    // Load-use on rs.
    set_ex(1'b1, 5'd5);
    set_dec(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'h3, 5'd5, 5'd6, 5'd8, 1'b1, 1'b0);
    settle(); chk_cycle("lu_rs_bub", 23'd0, 1'b1, 1'b0);
    tick(); sc_exp++;
    set_ex(1'b0, 5'd0);
    settle(); chk_cycle("lu_rs_iss", 23'b0_0_1_0_0011_00101_00110_01000, 1'b0, 1'b0);
    chk("lu_rs_iss.rs", 32'(iss_rs), 32'd5);
    tick();

    // Load-use on rt.
    set_ex(1'b1, 5'd12);
    set_dec(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h7, 5'd1, 5'd12, 5'd0, 1'b1, 1'b1);
    settle(); chk_cycle("lu_rt_bub", 23'd0, 1'b1, 1'b0);
    tick(); sc_exp++;
    set_ex(1'b0, 5'd12);
    settle(); chk_cycle("lu_rt_iss", pass_vec(), 1'b0, 1'b0);
    tick();

    // No false hazards: r0 load, unused rt match, invalid decode.
    set_ex(1'b1, 5'd0);
    set_dec(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'h2, 5'd0, 5'd0, 5'd4, 1'b1, 1'b1);
    settle(); chk_cycle("nf_r0", pass_vec(), 1'b0, 1'b0);
    tick();
    set_ex(1'b1, 5'd5);
    set_dec(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'h1, 5'd1, 5'd5, 5'd6, 1'b1, 1'b0);
    settle(); chk_cycle("nf_rt_unused", pass_vec(), 1'b0, 1'b0);
    tick();
    set_dec(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h1, 5'd5, 5'd5, 5'd6, 1'b1, 1'b1);
    settle(); chk_cycle("nf_invalid", 23'd0, 1'b0, 1'b0);
    tick();

    // Terminate reading a loaded register: one bubble, then issue, drain, halt.
    set_ex(1'b1, 5'd7);
    set_dec(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 5'd7, 5'd0, 5'd0, 1'b1, 1'b0);
    settle(); chk_cycle("ht_bub", 23'd0, 1'b1, 1'b0);
    tick(); sc_exp++;
    set_ex(1'b0, 5'd0);
    settle(); chk_cycle("ht_iss", 23'b0_0_0_1_0000_00111_00000_00000, 1'b0, 1'b0);
    tick();
    for (int i = 1; i <= 4; i++) begin
      settle(); chk_cycle($sformatf("drain%0d", i), 23'd0, 1'b1, 1'b0);
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      set_ex(1'b1, 5'd7);  // hazard-shaped input must be ignored in HALT
      settle(); chk_cycle($sformatf("halt%0d", i), 23'd0, 1'b1, 1'b1);
      tick();
    end

    // Reset out of HALT, then terminate again and reset mid-drain.
    rst = 1'b0;
    set_ex(1'b0, 5'd0);
    settle(); chk_cycle("rst_halt", 23'd0, 1'b0, 1'b1);
    tick(); sc_exp = 0;
    rst = 1'b1;
    set_dec(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    settle(); chk_cycle("t2_iss", 23'b0_0_0_1_0000_00000_00000_00000, 1'b0, 1'b0);
    tick();
    settle(); chk_cycle("t2_drain1", 23'd0, 1'b1, 1'b0);
    tick();
    rst = 1'b0;
    settle(); chk_cycle("t2_rst", 23'd0, 1'b0, 1'b0);
    tick();
    rst = 1'b1;
    set_dec(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'hC, 5'd2, 5'd3, 5'd4, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) begin
      settle(); chk_cycle($sformatf("post_rst%0d", i), pass_vec(), 1'b0, 1'b0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/id_issue_ctrl.md
# id_issue_ctrl

ID-stage issue controller that produces the control/register-index fields captured by the ID/EX pipeline register each cycle. It detects load-use hazards against the instruction currently in EX, inserts a bubble, and stalls the front end (PC, IF/ID) for that cycle. It also sequences processor termination: it issues the terminate instruction, drains the pipeline for a fixed number of cycles, and then reports halted. It sits between the decoder and the ID/EX register, and reads back the EX-side outputs of that register.

## Interface
- `DRAIN_CYCLES`, 4, cycles from terminate issue until `halted` rises minus one (EX, MEM, WB, writeback settle); legal range 1..15
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-low reset (0 = reset)
- `dec_valid`  in  1  decoder holds a valid instruction in ID
- `dec_mem_w`, `dec_mem_r`, `dec_wb_en`, `dec_terminate`  in  1 each  decoded controls
- `dec_alu_op`  in  4  decoded ALU op
- `dec_rs`, `dec_rt`, `dec_dest`  in  5 each  decoded register indices
- `dec_uses_rs`, `dec_uses_rt`  in  1 each  instruction reads rs / rt as a source
- `ex_mem_r`  in  1  instruction in EX is a load (ID/EX `mem_r` output)
- `ex_reg_dest`  in  5  destination of instruction in EX (ID/EX `reg_dest` output)
- `iss_mem_w`, `iss_mem_r`, `iss_wb_en`, `iss_terminate`  out  1 each  to ID/EX inputs
- `iss_alu_op`  out  4  to ID/EX input
- `iss_rs`, `iss_rt`, `iss_dest`  out  5 each  to ID/EX inputs
- `stall`  out  1  hold PC and IF/ID this cycle
- `halted`  out  1  registered; pipeline fully drained after terminate
- `stall_count`  out  `WORD`  load-use stall cycles (see Configuration)

## Operation
- Bubble: all `iss_*` = 0 (no memory access, no writeback, no terminate, rs/rt/dest = 0).
- Hazard (combinational): `haz = dec_valid & ex_mem_r & (ex_reg_dest != 0) & ((dec_uses_rs & dec_rs == ex_reg_dest) | (dec_uses_rt & dec_rt == ex_reg_dest))`.
- States: RUN, DRAIN, HALT; 4-bit down-counter `cnt`.
- RUN, `dec_valid=0`: bubble, `stall=0`.
- RUN, `haz=1`: bubble, `stall=1`; the next cycle EX holds the bubble, so the hazard clears and the instruction issues (load data forwarded from MEM). Exactly one bubble per load-use hazard.
- RUN, `dec_valid=1`, `haz=0`: pass decoded fields to `iss_*`, `stall=0`. If `dec_terminate=1`: next state DRAIN, `cnt <= DRAIN_CYCLES-1`.
- A hazard has priority over terminate: a terminate that reads a loaded register is bubbled once, then issues.
- DRAIN: bubble, `stall=1`; `cnt` decrements; when `cnt==0`, next state HALT.
- HALT: bubble, `stall=1`, `halted=1`; remains until reset. All `dec_*` inputs are ignored in DRAIN and HALT.
- `rst=0`: state RUN, `cnt=0`, `halted=0`, `stall_count=0`. While `rst=0`, outputs are bubble with `stall=0`.
- Reset in DRAIN or HALT returns to RUN on the next edge; `halted` falls in the same edge.

## Timing
- `iss_*` and `stall` are combinational from `dec_*`, `ex_*` and the state (zero latency); the ID/EX register adds the one-cycle stage delay.
- Terminate issued in cycle T: DRAIN during T+1 .. T+DRAIN_CYCLES; `halted=1` from T+DRAIN_CYCLES+1.
- `stall` is high for every DRAIN and HALT cycle, starting at T+1.
- Hazard stall: the stall and bubble occur in the cycle the hazard is seen; the instruction issues in the next cycle if `dec_*` is held, as the front end guarantees under `stall`.

## Configuration
- `ISSUE_STALL_CNT_EN` defined: `stall_count` increments by 1 at each rising edge where state=RUN and `haz=1` and `rst=1`. It saturates at all-ones and clears on reset.
- `ISSUE_STALL_CNT_EN` undefined: no counter register; `stall_count` is tied to 0.

## Test plan
- Reset: hold `rst=0` for 2 cycles with `dec_valid=1`, `dec_terminate=1` -> all `iss_*`=0, `stall=0`, `halted=0`, `stall_count=0`; no DRAIN entered.
- Load-use: EX has `ex_mem_r=1`, `ex_reg_dest=5`; ID has `dec_rs=5`, `dec_uses_rs=1` -> that cycle bubble and `stall=1`. Next cycle (`ex_mem_r=0`): `iss_rs=5`, `stall=0`; `stall_count=1` when enabled.
- No false hazard: `ex_reg_dest=0` with `dec_rs=0`, and `dec_rt=5` with `dec_uses_rt=0` -> both issue with `stall=0`.
- Terminate, DRAIN_CYCLES=4: terminate issued at cycle 10 with `iss_terminate=1` -> `stall=1` during cycles 11..14; `halted=1` from cycle 15 and stays high; `iss_*` remain 0.
- Hazard plus terminate: a terminate that reads load dest 7 -> one bubble, then `iss_terminate=1` the next cycle.
- Reset mid-DRAIN (cycle 12 in the case above) -> RUN after the edge, `halted` never rises, the next valid instruction issues.
